// File: rtl/datapath_legv8_mem.sv
// LEGv8 datapath (register file, ALU, status/IR/PC) with a req/ack memory port.
// A two-state sequencer runs fetch/load/store transactions and stalls the datapath while waiting.
module datapath_legv8_mem #(
    parameter int                 DATA_W        = 64,
    parameter int                 ADDR_W        = 32,
    parameter int                 NREGS         = 32,
    parameter logic [ADDR_W-1:0]  PC_RESET_ADDR = '0,
    parameter int                 TIMEOUT       = 255,
    localparam int                RA_W          = $clog2(NREGS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] constant_i,
    input  logic [RA_W-1:0]   da_i,
    input  logic [RA_W-1:0]   sa_i,
    input  logic [RA_W-1:0]   sb_i,
    input  logic              w_i,
    input  logic [2:0]        fs_i,
    input  logic              c0_i,
    input  logic              bsel_i,
    input  logic              sl_i,
    input  logic              il_i,
    input  logic [1:0]        ps_i,
    input  logic              pcsel_i,
    input  logic              start_if_i,
    input  logic              start_ld_i,
    input  logic              start_st_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] f_o,
    output logic [3:0]        status_o,
    output logic [3:0]        sr_out_o,
    output logic [31:0]       ir_out_o,
    output logic [ADDR_W-1:0] pc_out_o
);
    localparam int         SH_W    = $clog2(DATA_W);
    localparam int         XZR     = NREGS - 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic       {S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {K_IF, K_LD, K_ST} kind_t;

    state_t            state_q;
    kind_t             kind_q;
    logic [RA_W-1:0]   da_q;
    logic [7:0]        cnt_q;
    logic              mem_req_q, mem_we_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q, pc_q, pc_d;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [31:0]       ir_q;
    logic [3:0]        sr_q;

    logic [DATA_W-1:0] regs_q [NREGS-1];
    logic [DATA_W-1:0] a_val, b_val, b_op, add_b, f;
    logic [DATA_W:0]   sum;
    logic              c_flag, v_flag;
    logic              idle, ld_ack, start_any;
    logic [NREGS-2:0]  w_wen, ld_wen;

    // XZR is not stored; any index at or above it reads as zero
    assign a_val = (int'(sa_i) >= XZR) ? '0 : regs_q[sa_i];
    assign b_val = (int'(sb_i) >= XZR) ? '0 : regs_q[sb_i];
    assign b_op  = bsel_i ? constant_i : b_val;
    assign add_b = fs_i[0] ? ~b_op : b_op;
    assign sum   = {1'b0, a_val} + {1'b0, add_b} + {{DATA_W{1'b0}}, c0_i};

    always_comb begin
        f      = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (fs_i)
            3'b000: f = a_val & b_op;
            3'b001: f = a_val | b_op;
            3'b010, 3'b011: begin
                f      = sum[DATA_W-1:0];
                c_flag = sum[DATA_W];
                v_flag = (a_val[DATA_W-1] == add_b[DATA_W-1]) &&
                         (sum[DATA_W-1] != a_val[DATA_W-1]);
            end
            3'b100: f = a_val ^ b_op;
            3'b101: f = a_val << b_op[SH_W-1:0];
            3'b110: f = a_val >> b_op[SH_W-1:0];
            default: f = b_op;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (ps_i)
            2'b01:   pc_d = pc_q + ADDR_W'(4);
            2'b10:   pc_d = pc_q + {constant_i[ADDR_W-3:0], 2'b00};
            2'b11:   pc_d = pcsel_i ? constant_i[ADDR_W-1:0] : a_val[ADDR_W-1:0];
            default: pc_d = pc_q;
        endcase
    end

    assign idle      = (state_q == S_IDLE);
    assign ld_ack    = (state_q == S_WAIT) && mem_ack_i && (kind_q == K_LD);
    assign start_any = start_if_i | start_ld_i | start_st_i;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS - 1; gi++) begin : g_reg
            assign w_wen[gi]  = idle && w_i && (da_i == RA_W'(gi));
            assign ld_wen[gi] = ld_ack && (da_q == RA_W'(gi));
            always_ff @(posedge clock_i) begin
                if (reset_i)
                    regs_q[gi] <= '0;
                else if (ld_wen[gi])
                    regs_q[gi] <= mem_rdata_i;
                else if (w_wen[gi])
                    regs_q[gi] <= f;
            end
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            kind_q      <= K_IF;
            da_q        <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ir_q        <= '0;
            sr_q        <= '0;
            pc_q        <= PC_RESET_ADDR;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sl_i) sr_q <= {v_flag, c_flag, f[DATA_W-1], (f == '0)};
                    if (il_i) ir_q <= constant_i[31:0];
                    pc_q <= pc_d;
                    if (start_any) begin
                        kind_q      <= start_if_i ? K_IF : (start_ld_i ? K_LD : K_ST);
                        da_q        <= da_i;
                        mem_addr_q  <= start_if_i ? pc_q : f[ADDR_W-1:0];
                        mem_wdata_q <= b_val;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= !start_if_i && !start_ld_i;
                        busy_q      <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack_i) begin
                        if (kind_q == K_IF) begin
                            ir_q <= mem_rdata_i[31:0];
                            pc_q <= pc_q + ADDR_W'(4);
                        end
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        // abort: no writeback, no done pulse
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign f_o         = f;
    assign status_o    = {v_flag, c_flag, f[DATA_W-1], (f == '0)};
    assign sr_out_o    = sr_q;
    assign ir_out_o    = ir_q;
    assign pc_out_o    = pc_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_datapath_legv8_mem.sv
// Bench for datapath_legv8_mem: ALU vector table, randomized datapath vs. reference model,
// and hand-written memory transaction sequences (load, fetch, store timeout, XZR, reset in wait).
module tb_datapath_legv8_mem;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] constant;
    logic [4:0]    da, sa, sb;
    logic          w, c0, bsel, sl, il, pcsel;
    logic [2:0]    fs;
    logic [1:0]    ps;
    logic          start_if, start_ld, start_st;
    logic          mem_req, mem_we, mem_ack, busy, done, err;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] mem_wdata, mem_rdata, f;
    logic [3:0]    status, sr_out;
    logic [31:0]   ir_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datapath_legv8_mem #(
        .DATA_W(DW), .ADDR_W(AW), .NREGS(NR), .PC_RESET_ADDR('0), .TIMEOUT(4)
    ) dut (
        .clock_i(clk), .reset_i(reset), .constant_i(constant),
        .da_i(da), .sa_i(sa), .sb_i(sb), .w_i(w), .fs_i(fs), .c0_i(c0),
        .bsel_i(bsel), .sl_i(sl), .il_i(il), .ps_i(ps), .pcsel_i(pcsel),
        .start_if_i(start_if), .start_ld_i(start_ld), .start_st_i(start_st),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .busy_o(busy), .done_o(done), .err_o(err), .f_o(f), .status_o(status),
        .sr_out_o(sr_out), .ir_out_o(ir_out), .pc_out_o(pc_out)
    );

    typedef struct {
        logic [2:0]    fs;
        logic          c0;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] f;
        logic [3:0]    st;
    } vec_t;

    vec_t          vecs[14];
    logic [DW-1:0] rf_m [NR];
    logic [AW-1:0] pc_m;
    logic [3:0]    sr_m;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        constant = '0; da = '0; sa = 5'd31; sb = 5'd31;
        w = 0; fs = 3'b111; c0 = 0; bsel = 1; sl = 0; il = 0; ps = 2'b00; pcsel = 0;
        start_if = 0; start_ld = 0; start_st = 0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) rf_m[i] = '0;
        pc_m = '0;
        sr_m = '0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [DW-1:0] val);
        w = 1; da = idx; bsel = 1; constant = val; fs = 3'b111; ps = 2'b00; sl = 0;
        step();
        w = 0;
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [DW-1:0] val);
        sa = idx; bsel = 1; constant = '0; fs = 3'b001; c0 = 0;
        #1;
        val = f;
    endtask

    // Reference ALU: returns {V,C,N,Z, F} from the arithmetic definition of each op
    function automatic logic [DW+3:0] alu_ref(input logic [2:0] op, input logic cin,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0]        r;
        logic                 cf, vf;
        logic [DW-1:0]        bb;
        logic [DW:0]          u;
        logic signed [DW+1:0] s;
        r = '0; cf = 0; vf = 0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2, 3'd3: begin
                bb = (op == 3'd2) ? b : ~b;
                u  = {1'b0, a} + {1'b0, bb} + (DW+1)'(cin);
                r  = u[DW-1:0];
                cf = u[DW];
                s  = $signed({{2{a[DW-1]}}, a}) + $signed({{2{bb[DW-1]}}, bb})
                     + $signed({{(DW+1){1'b0}}, cin});
                vf = (s[DW+1:DW-1] != 3'b000) && (s[DW+1:DW-1] != 3'b111);
            end
            3'd4: r = a ^ b;
            3'd5: r = a << (b % DW);
            3'd6: r = a >> (b % DW);
            default: r = b;
        endcase
        return {vf, cf, r[DW-1], (r == '0), r};
    endfunction

    initial begin
        logic [DW-1:0] rv, a_m, b_m;
        logic [DW+3:0] exp_v;
        int            req_cycles;
        logic          seen_done;

        vecs[0]  = '{3'b000, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000};
        vecs[1]  = '{3'b001, 1'b0, 64'h0, 64'h0, 64'h0, 4'b0001};
        vecs[2]  = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0101};
        vecs[3]  = '{3'b010, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1010};
        vecs[4]  = '{3'b010, 1'b1, 64'h1, 64'h2, 64'h4, 4'b0000};
        vecs[5]  = '{3'b011, 1'b1, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010};
        vecs[6]  = '{3'b011, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};
        vecs[7]  = '{3'b011, 1'b1, 64'h5, 64'h5, 64'h0, 4'b0101};
        vecs[8]  = '{3'b100, 1'b0, 64'hFF, 64'h0F, 64'hF0, 4'b0000};
        vecs[9]  = '{3'b101, 1'b0, 64'h1, 64'd63, 64'h8000_0000_0000_0000, 4'b0010};
        vecs[10] = '{3'b101, 1'b0, 64'h1, 64'd65, 64'h2, 4'b0000};
        vecs[11] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'h1, 4'b0000};
        vecs[12] = '{3'b111, 1'b0, 64'd123, 64'h0, 64'h0, 4'b0001};
        vecs[13] = '{3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                     64'h8000_0000_0000_0000, 4'b0010};

        clear_ctl();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        chk("reset_pc", DW'(pc_out), 64'h0);
        chk("reset_sr", DW'(sr_out), 64'h0);
        chk("reset_ir", DW'(ir_out), 64'h0);
        chk("reset_err", DW'(err), 64'h0);
        chk("reset_req", DW'(mem_req), 64'h0);
        chk("reset_busy", DW'(busy), 64'h0);

        // reg1 = 5, then 5 - 3 with status load
        write_reg(5'd1, 64'd5);
        sa = 5'd1; bsel = 1; constant = 64'd3; fs = 3'b011; c0 = 1; sl = 1;
        #1;
        chk("sub_f", f, 64'd2);
        step();
        sl = 0;
        chk("sub_sr", DW'(sr_out), 64'b0100);
        $display("txn alu sub F=%0h SR=%b", f, sr_out);

        foreach (vecs[i]) begin
            write_reg(5'd2, vecs[i].a);
            sa = 5'd2; bsel = 1; constant = vecs[i].b; fs = vecs[i].fs; c0 = vecs[i].c0;
            #1;
            chk($sformatf("vec%0d_f", i), f, vecs[i].f);
            chk($sformatf("vec%0d_status", i), DW'(status), DW'(vecs[i].st));
            $display("txn vec%0d fs=%b F=%0h status=%b", i, fs, f, status);
        end

        do_reset();
        for (int it = 0; it < 40; it++) begin
            da = 5'($urandom_range(0, NR - 1));
            write_reg(da, {$urandom, $urandom});
            if (da != 5'd31) rf_m[da] = constant;
            sa = 5'($urandom_range(0, NR - 1));
            sb = 5'($urandom_range(0, NR - 1));
            bsel = 1'($urandom_range(0, 1));
            constant = {$urandom, $urandom};
            fs = 3'($urandom_range(0, 7));
            c0 = 1'($urandom_range(0, 1));
            ps = 2'($urandom_range(0, 3));
            pcsel = 1'($urandom_range(0, 1));
            sl = 1'($urandom_range(0, 1));
            a_m = rf_m[sa];
            b_m = bsel ? constant : rf_m[sb];
            exp_v = alu_ref(fs, c0, a_m, b_m);
            #1;
            chk($sformatf("rnd%0d_f", it), f, exp_v[DW-1:0]);
            chk($sformatf("rnd%0d_status", it), DW'(status), DW'(exp_v[DW+3:DW]));
            case (ps)
                2'b01: pc_m = AW'(pc_m + 4);
                2'b10: pc_m = AW'(pc_m + constant * 4);
                2'b11: pc_m = pcsel ? AW'(constant) : AW'(a_m);
                default: ;
            endcase
            if (sl) sr_m = exp_v[DW+3:DW];
            step();
            ps = 2'b00; sl = 0;
            chk($sformatf("rnd%0d_pc", it), DW'(pc_out), DW'(pc_m));
            chk($sformatf("rnd%0d_sr", it), DW'(sr_out), DW'(sr_m));
            $display("txn rnd%0d fs=%b F=%0h PC=%0h", it, fs, f, pc_out);
        end

        clear_ctl();
        do_reset();
        // ack while idle must do nothing
        da = 5'd4; mem_ack = 1; mem_rdata = 64'h1111;
        step();
        mem_ack = 0;
        chk("idle_ack_done", DW'(done), 64'h0);
        read_reg(5'd4, rv);
        chk("idle_ack_reg", rv, 64'h0);

        // load with ack on third wait cycle; start_st same cycle loses priority
        sa = 5'd31; bsel = 1; constant = 64'h40; fs = 3'b111; da = 5'd5;
        start_ld = 1; start_st = 1;
        step();
        start_ld = 0; start_st = 0;
        chk("ld_we", DW'(mem_we), 64'h0);
        chk("ld_addr", DW'(mem_addr), 64'h40);
        chk("ld_busy", DW'(busy), 64'h1);
        ps = 2'b01; w = 1; da = 5'd7;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("ld_req_c%0d", k), DW'(mem_req), 64'h1);
            if (k == 3) begin
                mem_ack = 1; mem_rdata = 64'hDEAD;
            end
            step();
        end
        mem_ack = 0; ps = 2'b00; w = 0;
        chk("ld_req_drop", DW'(mem_req), 64'h0);
        chk("ld_done", DW'(done), 64'h1);
        chk("ld_pc_stall", DW'(pc_out), 64'h0);
        step();
        chk("ld_done_pulse", DW'(done), 64'h0);
        read_reg(5'd5, rv);
        chk("ld_reg5", rv, 64'hDEAD);
        read_reg(5'd7, rv);
        chk("ld_w_stalled", rv, 64'h0);
        $display("txn ld addr=40 data=%0h", 64'hDEAD);

        // fetch at PC=0, then back-to-back store that times out
        write_reg(5'd3, 64'h1234_5678_9ABC_DEF0);
        start_if = 1; start_ld = 1;
        step();
        start_if = 0; start_ld = 0; ps = 2'b01;
        chk("if_we", DW'(mem_we), 64'h0);
        chk("if_addr", DW'(mem_addr), 64'h0);
        mem_ack = 1; mem_rdata = 64'hCAFE_F00D_8B02_0020;
        step();
        mem_ack = 0; ps = 2'b00;
        chk("if_ir", DW'(ir_out), 64'h8B02_0020);
        chk("if_pc", DW'(pc_out), 64'h4);
        chk("if_done", DW'(done), 64'h1);
        $display("txn if addr=0 ir=%0h", ir_out);

        start_st = 1; sb = 5'd3; sa = 5'd31; bsel = 1; constant = 64'h100; fs = 3'b111;
        step();
        start_st = 0;
        chk("st_we", DW'(mem_we), 64'h1);
        chk("st_addr", DW'(mem_addr), 64'h100);
        chk("st_wdata", mem_wdata, 64'h1234_5678_9ABC_DEF0);
        req_cycles = 0;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            req_cycles++;
            step();
            seen_done |= done;
        end
        chk("st_timeout_cycles", DW'(req_cycles), 64'd4);
        chk("st_err", DW'(err), 64'h1);
        chk("st_no_done", DW'(seen_done), 64'h0);
        chk("st_busy", DW'(busy), 64'h0);
        $display("txn st addr=100 aborted after %0d cycles", req_cycles);

        // load into XZR; err stays sticky
        sa = 5'd31; bsel = 1; constant = 64'h80; fs = 3'b111; da = 5'd31; start_ld = 1;
        step();
        start_ld = 0; mem_ack = 1; mem_rdata = 64'hBEEF;
        step();
        mem_ack = 0;
        chk("xzr_done", DW'(done), 64'h1);
        chk("xzr_err_sticky", DW'(err), 64'h1);
        read_reg(5'd31, rv);
        chk("xzr_read", rv, 64'h0);
        $display("txn ld addr=80 to xzr");

        // reset while waiting
        sa = 5'd31; constant = 64'h0; fs = 3'b111; da = 5'd6; start_ld = 1;
        step();
        start_ld = 0;
        chk("rw_req", DW'(mem_req), 64'h1);
        reset = 1; mem_ack = 1; mem_rdata = 64'h55;
        step();
        chk("rw_req_drop", DW'(mem_req), 64'h0);
        chk("rw_busy", DW'(busy), 64'h0);
        chk("rw_err_clr", DW'(err), 64'h0);
        chk("rw_done", DW'(done), 64'h0);
        reset = 0; mem_ack = 0;
        step();
        read_reg(5'd6, rv);
        chk("rw_reg6", rv, 64'h0);
        read_reg(5'd5, rv);
        chk("rw_reg5_clr", rv, 64'h0);
        $display("txn ld addr=0 cancelled by reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
